writeback_stage: RTL and testbench

Y86-64 writeback stage with the architectural register file. It sits directly downstream of the memory stage and latches that stage's results into a W pipeline register. One cycle later it commits valE/valM to the 15-entry register file and updates processor status. It halts permanently on the first non-AOK status. It also provides combinational read ports for decode and a retired-instruction counter.

---
 rtl/writeback_stage_if.sv | 45 ++++
 rtl/writeback_stage.sv | 145 ++++++++++++++
 tb/tb_writeback_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// ---------------------------------------------------------------------------
// writeback_stage_if
//   Bundles the signals between the writeback stage and its neighbours:
//   the memory-stage result bus, the decode register-read ports and the
//   processor status outputs.
//
//   master : memory stage / decode side (drives results and read addresses)
//   slave  : writeback stage side (drives read data and status)
//
//   flag4, icode, valE, valM, dstE, dstM, stat_in, dmem_error : memory-stage result
//   srcA, srcB / rvalA, rvalB : combinational register read ports
//   flag5, stat, halted, retired : W-valid flag and processor status
// ---------------------------------------------------------------------------
interface writeback_stage_if #(
    parameter int CNTW = 32
);
    logic            flag4;
    logic [3:0]      icode;
    logic [63:0]     valE;
    logic [63:0]     valM;
    logic [3:0]      dstE;
    logic [3:0]      dstM;
    logic [2:0]      stat_in;
    logic            dmem_error;
    logic [3:0]      srcA;
    logic [3:0]      srcB;
    logic [63:0]     rvalA;
    logic [63:0]     rvalB;
    logic            flag5;
    logic [2:0]      stat;
    logic            halted;
    logic [CNTW-1:0] retired;

    modport master (
        output flag4, icode, valE, valM, dstE, dstM, stat_in, dmem_error,
        output srcA, srcB,
        input  rvalA, rvalB, flag5, stat, halted, retired
    );

    modport slave (
        input  flag4, icode, valE, valM, dstE, dstM, stat_in, dmem_error,
        input  srcA, srcB,
        output rvalA, rvalB, flag5, stat, halted, retired
    );
endinterface

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//   Y86-64 writeback stage. Latches the memory-stage result into the W
//   register, commits valE/valM to the architectural register file one edge
//   later, tracks processor status and stops permanently on the first
//   non-AOK entry. Also provides combinational decode read ports and a
//   retired-instruction counter.
//
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears registers, W, status, counter
//   bus   : writeback_stage_if.slave (memory-stage bus, read ports, status)
// ---------------------------------------------------------------------------
module writeback_stage #(
    parameter int NREG = 15,
    parameter int CNTW = 32
) (
    input  logic               clk,
    input  logic               reset,
    writeback_stage_if.slave   bus
);
    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [2:0] STAT_HLT  = 3'd2;
    localparam logic [2:0] STAT_ADR  = 3'd3;
    localparam logic [2:0] STAT_INS  = 3'd4;
    localparam logic [3:0] RNONE     = 4'hF;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] ICODE_MAX = 4'hB;

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_HALTED  = 1'b1;

    logic [63:0]     regs [NREG];
    logic [0:0]      state;

    // W pipeline register
    logic            w_valid;
    logic [3:0]      w_icode;
    logic [63:0]     w_valE;
    logic [63:0]     w_valM;
    logic [3:0]      w_dstE;
    logic [3:0]      w_dstM;
    logic [2:0]      w_stat;

    logic [2:0]      stat_q;
    logic            halted_q;
    logic [CNTW-1:0] retired_q;

    logic [2:0]      eff_stat;
    logic            w_commit;
    logic            w_fault;

    // Effective status of the incoming instruction, highest priority first.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        eff_stat = STAT_AOK;
        if (bus.dmem_error)
            eff_stat = STAT_ADR;
        else if (bus.stat_in != STAT_AOK)
            eff_stat = bus.stat_in;
        else if (bus.icode > ICODE_MAX)
            eff_stat = STAT_INS;
        else if (bus.icode == 4'h0)
            eff_stat = STAT_HLT;
    end

    // A halt entry never carries AOK status, so the icode term only
    // documents that halts are not counted as retired.
    assign w_commit = (state == S_RUN) && w_valid && (w_stat == STAT_AOK)
                      && (w_icode != 4'h0);
    assign w_fault  = (state == S_RUN) && w_valid && (w_stat != STAT_AOK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register file is reset explicitly because software
            // expects all architectural registers to start at zero; this
            // keeps it in flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            state     <= S_RUN;
            w_valid   <= 1'b0;
            w_icode   <= ICODE_NOP;
            w_valE    <= '0;
            w_valM    <= '0;
            w_dstE    <= RNONE;
            w_dstM    <= RNONE;
            w_stat    <= STAT_AOK;
            stat_q    <= STAT_AOK;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let this edge's commit read the
            // old W contents while the same edge loads the next entry.
            if (w_commit) begin
                if (w_dstE != RNONE && int'(w_dstE) < NREG)
                    regs[w_dstE] <= w_valE;
                // Issued after the valE write so valM wins when dstE == dstM.
                if (w_dstM != RNONE && int'(w_dstM) < NREG)
                    regs[w_dstM] <= w_valM;
                retired_q <= retired_q + 1'b1;
            end

            if (w_fault) begin
                stat_q   <= w_stat;
                halted_q <= 1'b1;
                state    <= S_HALTED;
            end

            // Capture only while running and not faulting on this edge;
            // otherwise W becomes (and stays) a bubble.
            if (state == S_RUN && !w_fault && bus.flag4) begin
                w_valid <= 1'b1;
                w_icode <= bus.icode;
                w_valE  <= bus.valE;
                w_valM  <= bus.valM;
                w_dstE  <= bus.dstE;
                w_dstM  <= bus.dstM;
                w_stat  <= eff_stat;
            end else begin
                w_valid <= 1'b0;
                w_icode <= ICODE_NOP;
                w_valE  <= '0;
                w_valM  <= '0;
                w_dstE  <= RNONE;
                w_dstM  <= RNONE;
                w_stat  <= STAT_AOK;
            end
        end
    end

    // Read ports see only the architectural file; no bypass from W.
    always_comb begin
        bus.rvalA = '0;
        bus.rvalB = '0;
        if (bus.srcA != RNONE && int'(bus.srcA) < NREG)
            bus.rvalA = regs[bus.srcA];
        if (bus.srcB != RNONE && int'(bus.srcB) < NREG)
            bus.rvalB = regs[bus.srcB];
    end

    assign bus.flag5   = w_valid;
    assign bus.stat    = stat_q;
    assign bus.halted  = halted_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
//   Self-checking bench for writeback_stage. A transaction-level model
//   (array register file plus one pending-entry record) predicts register
//   contents, status and the retired count; directed and random steps run
//   in one initial block.
// ---------------------------------------------------------------------------
module tb_writeback_stage;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    writeback_stage_if #(.CNTW(32)) bus ();

    writeback_stage #(.NREG(15), .CNTW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        bit          valid;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [2:0]  st;
    } entry_t;

    logic [63:0] m_regs [16];
    entry_t      m_w;
    logic [2:0]  m_stat;
    bit          m_halted;
    logic [31:0] m_retired;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] spec_status(logic dmem_err, logic [2:0] sin,
                                               logic [3:0] ic);
        if (dmem_err)        return 3'd3;
        if (sin != 3'd1)     return sin;
        if (ic > 4'hB)       return 3'd4;
        if (ic == 4'h0)      return 3'd2;
        return 3'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_w       = '{valid: 1'b0, valE: '0, valM: '0, dstE: 4'hF, dstM: 4'hF, st: 3'd1};
        m_stat    = 3'd1;
        m_halted  = 1'b0;
        m_retired = '0;
    endtask

    // One clock edge as seen by the architecture: retire the pending
    // instruction, then accept the next one if the machine is still running.
    task automatic model_edge();
        if (!m_halted && m_w.valid) begin
            if (m_w.st == 3'd1) begin
                if (m_w.dstE != 4'hF) m_regs[m_w.dstE] = m_w.valE;
                if (m_w.dstM != 4'hF) m_regs[m_w.dstM] = m_w.valM;
                m_retired = m_retired + 1;
            end else begin
                m_stat   = m_w.st;
                m_halted = 1'b1;
            end
        end
        if (!m_halted && bus.flag4)
            m_w = '{valid: 1'b1, valE: bus.valE, valM: bus.valM, dstE: bus.dstE,
                    dstM: bus.dstM, st: spec_status(bus.dmem_error, bus.stat_in, bus.icode)};
        else
            m_w = '{valid: 1'b0, valE: '0, valM: '0, dstE: 4'hF, dstM: 4'hF, st: 3'd1};
    endtask

    task automatic check_state(string tag);
        check({tag, ".flag5"},   64'(bus.flag5),   64'(m_w.valid));
        check({tag, ".stat"},    64'(bus.stat),    64'(m_stat));
        check({tag, ".halted"},  64'(bus.halted),  64'(m_halted));
        check({tag, ".retired"}, 64'(bus.retired), 64'(m_retired));
    endtask

    task automatic read_check(string tag, logic [3:0] a, logic [3:0] b);
        bus.srcA = a;
        bus.srcB = b;
        #1;
        check($sformatf("%s.rvalA[%0d]", tag, a), bus.rvalA, m_regs[a]);
        check($sformatf("%s.rvalB[%0d]", tag, b), bus.rvalB, m_regs[b]);
    endtask

    task automatic drive(logic f4, logic [3:0] ic, logic [63:0] ve, logic [63:0] vm,
                         logic [3:0] de, logic [3:0] dm, logic [2:0] si, logic derr);
        bus.flag4      = f4;
        bus.icode      = ic;
        bus.valE       = ve;
        bus.valM       = vm;
        bus.dstE       = de;
        bus.dstM       = dm;
        bus.stat_in    = si;
        bus.dmem_error = derr;
    endtask

    task automatic idle();
        drive(1'b0, 4'h1, '0, '0, 4'hF, 4'hF, 3'd1, 1'b0);
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_state(tag);
    endtask

    // Asynchronous pulse placed between clock edges.
    task automatic pulse_reset(string tag);
        reset = 1'b1;
        model_reset();
        #1;
        check_state(tag);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        bus.srcA = 4'hF;
        bus.srcB = 4'hF;
        model_reset();
        #12;
        check_state("reset");
        reset = 1'b0;

        // Every read address, including RNONE, reads zero after reset.
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            bus.srcA = 4'(i);
            bus.srcB = 4'(15 - i);
            #0.5;
            check($sformatf("reset.rvalA[%0d]", i), bus.rvalA, 64'd0);
            check($sformatf("reset.rvalB[%0d]", 15 - i), bus.rvalB, 64'd0);
        end

        // Single valE write; old value visible until the commit edge.
        @(negedge clk);
        drive(1'b1, 4'h6, 64'd8, 64'd0, 4'd2, 4'hF, 3'd1, 1'b0);
        tick("opq");
        read_check("opq.old", 4'd2, 4'd2);
        idle();
        tick("opq.commit");
        read_check("opq.new", 4'd2, 4'hF);

        // dstE == dstM: valM wins.
        drive(1'b1, 4'hB, 64'd16, 64'd42, 4'd4, 4'd4, 3'd1, 1'b0);
        tick("popq");
        idle();
        tick("popq.commit");
        read_check("popq", 4'd4, 4'd4);

        // Back-to-back stream to registers 0..3.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h2, {$urandom, $urandom}, 64'd0, 4'(i), 4'hF, 3'd1, 1'b0);
            tick($sformatf("stream%0d", i));
        end
        idle();
        tick("stream.drain");
        read_check("stream", 4'd0, 4'd1);
        read_check("stream", 4'd2, 4'd3);

        // Random AOK traffic with random valid gaps and destinations.
        for (int n = 0; n < 40; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(1, 11)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'd1, 1'b0);
            tick($sformatf("rand%0d", n));
            read_check("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        idle();
        tick("rand.drain");

        // Data-memory error: no write, ADR, halted; later traffic ignored.
        drive(1'b1, 4'h5, 64'd0, 64'd99, 4'hF, 4'd3, 3'd1, 1'b1);
        tick("adr");
        drive(1'b1, 4'h6, 64'd123, 64'd0, 4'd1, 4'hF, 3'd1, 1'b0);
        tick("adr.fault");
        tick("adr.hold1");
        tick("adr.hold2");
        idle();
        read_check("adr", 4'd3, 4'd1);

        pulse_reset("rst.after_adr");
        read_check("rst.after_adr", 4'd3, 4'd2);

        // Halt: counted as not retired.
        drive(1'b1, 4'h6, 64'd7, 64'd0, 4'd6, 4'hF, 3'd1, 1'b0);
        tick("pre_hlt");
        drive(1'b1, 4'h0, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1, 1'b0);
        tick("hlt");
        idle();
        tick("hlt.fault");
        read_check("hlt", 4'd6, 4'hF);
        pulse_reset("rst.after_hlt");
        read_check("rst.after_hlt", 4'd6, 4'd0);

        // Invalid icode.
        drive(1'b1, 4'hD, 64'd5, 64'd0, 4'd7, 4'hF, 3'd1, 1'b0);
        tick("ins");
        idle();
        tick("ins.fault");
        read_check("ins", 4'd7, 4'hF);
        pulse_reset("rst.after_ins");

        // Priority: dmem_error beats a non-AOK stat_in.
        drive(1'b1, 4'h6, 64'd5, 64'd0, 4'd8, 4'hF, 3'd4, 1'b1);
        tick("prio_adr");
        idle();
        tick("prio_adr.fault");
        pulse_reset("rst.prio_adr");

        // Priority: stat_in beats an invalid icode.
        drive(1'b1, 4'hE, 64'd5, 64'd0, 4'd8, 4'hF, 3'd2, 1'b0);
        tick("prio_sin");
        idle();
        tick("prio_sin.fault");
        read_check("prio_sin", 4'd8, 4'hF);
        pulse_reset("rst.prio_sin");

        // Async reset with a valid W entry: discarded, flag5 drops at once.
        drive(1'b1, 4'h3, 64'd77, 64'd0, 4'd5, 4'hF, 3'd1, 1'b0);
        tick("inflight");
        idle();
        #1;
        pulse_reset("inflight.rst");
        tick("inflight.after1");
        tick("inflight.after2");
        read_check("inflight", 4'd5, 4'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
